sram_arbiter: RTL
=================

Name: sram_arbiter

Overview:
Two-requester arbiter for the single-port SRAM shared by the CPU instruction-fetch unit (port 0) and the CPU load/store unit (port 1).
- Grants at most one access per cycle and drives the SRAM port.
- Returns synchronous read data one cycle later to the port that issued the read.
- Data port has priority; a starvation counter guarantees fetch progress.

Parameters:
ADDR_W, 8, SRAM word-address width (256 words; program, data array and result words all live here)
DATA_W, 16, SRAM word width
MAX_CONSEC, 4, maximum consecutive data grants while a fetch request is pending (1..15)

Ports:
clk  in  1  system clock, all state on rising edge
reset  in  1  asynchronous, active-low reset
if_req  in  1  fetch request; held with if_addr until if_gnt
if_addr  in  ADDR_W  fetch address
if_gnt  out  1  fetch request accepted this cycle
if_rvalid  out  1  if_rdata valid (cycle after if_gnt)
if_rdata  out  DATA_W  fetch read data
d_req  in  1  data request; held with d_we/d_addr/d_wdata until d_gnt
d_we  in  1  1 = write, 0 = read
d_addr  in  ADDR_W  data address
d_wdata  in  DATA_W  write data
d_gnt  out  1  data request accepted this cycle
d_rvalid  out  1  d_rdata valid (cycle after read grant; never for writes)
d_rdata  out  DATA_W  data read data
mem_en  out  1  SRAM access enable
mem_we  out  1  SRAM write enable
mem_addr  out  ADDR_W  SRAM address
mem_wdata  out  DATA_W  SRAM write data
mem_rdata  in  DATA_W  SRAM read data, valid one cycle after mem_en with mem_we=0

Behaviour:
- Reset (reset=0, async): if_rvalid, d_rvalid, starve_cnt and rd_owner cleared. Combinational outputs then follow the rule below, so with no requests all outputs read 0.
- Grant decision (combinational, same cycle as requests):
  - only if_req → fetch
  - only d_req → data
  - both, starve_cnt < MAX_CONSEC → data
  - both, starve_cnt == MAX_CONSEC → fetch
- Gnt outputs: exactly one of if_gnt/d_gnt high when any request is present; both low otherwise.
- SRAM drive: mem_en = if_gnt | d_gnt. mem_addr/mem_we/mem_wdata come from the winner (fetch: mem_we=0, mem_wdata=0). When idle, mem_addr, mem_we and mem_wdata are 0.
- starve_cnt (4 bits, registered):
  - increments on a data grant while if_req=1
  - clears on any fetch grant, or whenever if_req=0
  - never exceeds MAX_CONSEC
- Read return:
  - rd_owner register records the winner of a read grant.
  - Next cycle, the owner's rvalid=1 and its rdata = mem_rdata (pass-through); the other port's rdata = 0.
  - rvalid is a 1-cycle pulse per read grant.
- Throughput: back-to-back grants every cycle. A new grant may coincide with the rvalid of the previous one.
- Writes: d_gnt=1 with d_we=1 completes the write in that cycle; no rvalid. A read of the same address in the next cycle returns the new data (SRAM write-first not required; read is a later cycle).
- Protocol errors (not checked): a requester dropping req before gnt is illegal. Changing address while waiting is illegal.
- Reset mid-operation: a pending rvalid is cancelled (no pulse after reset deassertion). starve_cnt restarts at 0.

Decomposition:
- Shared package cpu_mem_pkg: ADDR_W and DATA_W defaults, owner encoding constants (OWN_IF=0, OWN_D=1), MAX_CONSEC default.
- One sub-module, natural: sram_arb_prio. Combinational priority/starvation grant logic, with starve_cnt as input and grant vector as output. Counter and read-return registers stay in sram_arbiter.

Test Plan:
1. Fetch only: if_req=1, if_addr=0x00,0x01,0x02 over consecutive cycles, SRAM preloaded → if_gnt=1 each cycle. if_rvalid on the following cycles with words mem[0..2]. d_gnt=0 and d_rvalid=0 throughout.
2. Data write then read: d_we=1, d_addr=99, d_wdata=16'd735 → d_gnt=1, mem_we=1, no d_rvalid. Next cycle, read d_addr=99 → one cycle later d_rvalid=1, d_rdata=735.
3. Contention: if_req and d_req held high continuously, MAX_CONSEC=4 → grant pattern D,D,D,D,I repeating. if_rvalid/d_rvalid follow each read grant by exactly one cycle.
4. Starvation reset: both requesting, 2 data grants, then if_req=0 for one cycle, then if_req=1 again → starve_cnt cleared, so fetch is granted only after 4 further data grants.
5. Read-score loop: d_req reads addresses 100..109 back-to-back while fetch requests interleave → each d_rdata matches the score word preloaded at that address, in order, with no lost or duplicated rvalid.
6. Async reset: assert reset=0 mid-cycle right after a read grant → if_rvalid/d_rvalid never pulse. All outputs 0 (no requests applied). Normal grants resume on the first clk edge after release.

Source files
------------

// File: rtl/cpu_mem_pkg.sv
// Shared constants for the CPU-side SRAM path: default widths, read-owner encoding
// and the starvation counter helpers used by the fetch/data arbiter.
package cpu_mem_pkg;

  localparam int unsigned ADDR_W_DFLT     = 8;
  localparam int unsigned DATA_W_DFLT     = 16;
  localparam int unsigned MAX_CONSEC_DFLT = 4;
  localparam int unsigned CNT_W           = 4;

  // Read-owner encoding, also the bit index into the grant vector.
  localparam logic OWN_IF = 1'b0;
  localparam logic OWN_D  = 1'b1;

  typedef logic [1:0]       gnt_vec_t;
  typedef logic [CNT_W-1:0] starve_cnt_t;

  // Counter only advances while fetch is actually being held off by a data grant.
  function automatic starve_cnt_t starve_next(input starve_cnt_t cnt,
                                              input logic        if_req,
                                              input gnt_vec_t    gnt,
                                              input starve_cnt_t max_cnt);
    starve_cnt_t nxt;
    nxt = cnt;
    if (!if_req || gnt[OWN_IF]) begin
      nxt = '0;
    end else if (gnt[OWN_D] && (cnt < max_cnt)) begin
      nxt = cnt + starve_cnt_t'(1);
    end
    return nxt;
  endfunction

endpackage

// File: rtl/sram_arb_prio.sv
// Grant selection between fetch and data: data wins unless fetch has waited out
// MAX_CONSEC consecutive data grants.
module sram_arb_prio
  import cpu_mem_pkg::*;
#(
  parameter int unsigned MAX_CONSEC = MAX_CONSEC_DFLT
) (
  input  logic        if_req,
  input  logic        d_req,
  input  starve_cnt_t starve_cnt,
  output gnt_vec_t    gnt
);

  localparam starve_cnt_t MaxCnt = starve_cnt_t'(MAX_CONSEC);

  always_comb begin
    gnt = '0;
    if (if_req && d_req) begin
      if (starve_cnt >= MaxCnt) begin
        gnt[OWN_IF] = 1'b1;
      end else begin
        gnt[OWN_D] = 1'b1;
      end
    end else if (if_req) begin
      gnt[OWN_IF] = 1'b1;
    end else if (d_req) begin
      gnt[OWN_D] = 1'b1;
    end
  end

endmodule

// File: rtl/sram_arbiter.sv
// Single-port SRAM arbiter between instruction fetch (port 0) and load/store (port 1);
// read data passes through to the port that owned the read one cycle earlier.
module sram_arbiter
  import cpu_mem_pkg::*;
#(
  parameter int unsigned ADDR_W     = ADDR_W_DFLT,
  parameter int unsigned DATA_W     = DATA_W_DFLT,
  parameter int unsigned MAX_CONSEC = MAX_CONSEC_DFLT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [DATA_W-1:0] d_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam starve_cnt_t MaxCnt = starve_cnt_t'(MAX_CONSEC);

  gnt_vec_t    gnt;
  starve_cnt_t starve_cnt_q, starve_cnt_d;
  logic        rd_valid_q;
  logic        rd_owner_q;

  sram_arb_prio #(
    .MAX_CONSEC (MAX_CONSEC)
  ) u_prio (
    .if_req     (if_req),
    .d_req      (d_req),
    .starve_cnt (starve_cnt_q),
    .gnt        (gnt)
  );

  assign if_gnt = gnt[OWN_IF];
  assign d_gnt  = gnt[OWN_D];
  assign mem_en = if_gnt | d_gnt;

  always_comb begin
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (d_gnt) begin
      mem_we    = d_we;
      mem_addr  = d_addr;
      mem_wdata = d_wdata;
    end else if (if_gnt) begin
      mem_addr  = if_addr;
    end
  end

  assign starve_cnt_d = starve_next(starve_cnt_q, if_req, gnt, MaxCnt);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      starve_cnt_q <= '0;
      rd_valid_q   <= 1'b0;
      rd_owner_q   <= OWN_IF;
    end else begin
      starve_cnt_q <= starve_cnt_d;
      rd_valid_q   <= mem_en & ~mem_we;
      if (mem_en && !mem_we) begin
        rd_owner_q <= d_gnt ? OWN_D : OWN_IF;
      end
    end
  end

  always_comb begin
    if_rvalid = rd_valid_q && (rd_owner_q == OWN_IF);
    d_rvalid  = rd_valid_q && (rd_owner_q == OWN_D);
    if_rdata  = if_rvalid ? mem_rdata : '0;
    d_rdata   = d_rvalid ? mem_rdata : '0;
  end

endmodule
